// File: rtl/tile_assemble_3x3x4x4_8x10.sv
// tile_assemble_3x3x4x4_8x10
//   Collects nine 4x4 Winograd output tiles (3x3 grid, raster order) into an
//   8x10 pixel image. Elements that fall outside the image are dropped:
//   tile row 2 entirely, and columns 2..3 of tile column 2. The image is then
//   streamed out one pixel per handshake in row-major order.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   tile_in     one 4x4 tile, 32-bit elements, row-major [i][j]
//   tile_valid  tile_in holds a tile
//   tile_ready  block accepts a tile (high while collecting)
//   pix_data    assembled pixel value
//   pix_valid   pixel outputs valid (high while draining)
//   pix_ready   downstream accepts the pixel
//   pix_row     row 0..7 of the presented pixel
//   pix_col     column 0..9 of the presented pixel
//   pix_last    high on pixel (7,9) only
//   frame_count completed-frame counter, 16 bits, wraps
//               (present only when TILE_ASSEMBLE_FRAME_CNT_EN is defined)
//
// Build option: define TILE_ASSEMBLE_FRAME_CNT_EN to add frame_count.

module tile_assemble_3x3x4x4_8x10 (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:3][0:3][31:0]  tile_in,
  input  logic                   tile_valid,
  output logic                   tile_ready,
  output logic [31:0]            pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [3:0]             pix_row,
  output logic [3:0]             pix_col,
  output logic                   pix_last
`ifdef TILE_ASSEMBLE_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);

  localparam logic COLLECT = 1'b0;
  localparam logic DRAIN   = 1'b1;

  logic        state;
  logic [3:0]  tile_cnt;
  logic [1:0]  tile_r;
  logic [1:0]  tile_c;
  logic        tile_hs;
  logic        pix_hs;

  // Pixel store addressed by {row[2:0], col[3:0]}; only 80 of 128 entries used.
  logic [31:0] pix_mem [0:127];

  always_comb begin
    tile_r = '0;
    tile_c = '0;
    case (tile_cnt)
      4'd0:    begin tile_r = 2'd0; tile_c = 2'd0; end
      4'd1:    begin tile_r = 2'd0; tile_c = 2'd1; end
      4'd2:    begin tile_r = 2'd0; tile_c = 2'd2; end
      4'd3:    begin tile_r = 2'd1; tile_c = 2'd0; end
      4'd4:    begin tile_r = 2'd1; tile_c = 2'd1; end
      4'd5:    begin tile_r = 2'd1; tile_c = 2'd2; end
      4'd6:    begin tile_r = 2'd2; tile_c = 2'd0; end
      4'd7:    begin tile_r = 2'd2; tile_c = 2'd1; end
      default: begin tile_r = 2'd2; tile_c = 2'd2; end
    endcase
  end

  always_comb begin
    tile_ready = (state == COLLECT);
    pix_valid  = (state == DRAIN);
    pix_last   = pix_valid && (pix_row == 4'd7) && (pix_col == 4'd9);
    pix_data   = pix_mem[{pix_row[2:0], pix_col}];
    tile_hs    = tile_valid && tile_ready;
    pix_hs     = pix_valid && pix_ready;
  end

  // Tile row 2 maps entirely below the image, so only tile_r[0] reaches the
  // address; tile_r[1] just suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && tile_hs) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          if (!tile_r[1] && ({tile_c, 2'(j)} < 4'd10)) begin
            pix_mem[{tile_r[0], 2'(i), tile_c, 2'(j)}] <= tile_in[2'(i)][2'(j)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      tile_cnt <= '0;
      pix_row  <= '0;
      pix_col  <= '0;
`ifdef TILE_ASSEMBLE_FRAME_CNT_EN
      frame_count <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (tile_hs) begin
            if (tile_cnt == 4'd8) begin
              state <= DRAIN;
            end else begin
              tile_cnt <= tile_cnt + 4'd1;
            end
          end
        end
        default: begin
          if (pix_hs) begin
            if (pix_last) begin
              state    <= COLLECT;
              tile_cnt <= '0;
              pix_row  <= '0;
              pix_col  <= '0;
`ifdef TILE_ASSEMBLE_FRAME_CNT_EN
              frame_count <= frame_count + 16'd1;
`endif
            end else if (pix_col == 4'd9) begin
              pix_col <= '0;
              pix_row <= pix_row + 4'd1;
            end else begin
              pix_col <= pix_col + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
